pfcop_seq: RTL and testbench
============================

Name: pfcop_seq

Overview:
Parametrised, command-driven prime-field coprocessor. It is the successor to the fixed 16-bit load/execute/read coprocessor. It holds a generic operand register file plus a modulus register, and accepts modular add, subtract and multiply commands through a valid/ready handshake. Results are written back to any register and read out over a registered read port; `done`/`err` report completion.

Parameters:
WIDTH, 16, field element / data width in bits
NREG, 8, number of general operand registers (>=2)
AW, 3, register address width; must satisfy 2**AW >= NREG

Ports:
clk  input  1  clock, rising edge
rst  input  1  asynchronous reset, active low
load_en  input  1  write datain into register file this cycle
load_addr  input  AW  target register for load_en
load_mod  input  1  write datain into modulus register P
datain  input  WIDTH  load data
cmd_valid  input  1  command request
cmd_ready  output  1  high when a command can be accepted
cmd_op  input  2  00 madd, 01 msub, 10 mmul, 11 reserved
cmd_src_a  input  AW  operand A register
cmd_src_b  input  AW  operand B register
cmd_dst  input  AW  result register
busy  output  1  command in progress
done  output  1  one-cycle completion pulse
err  output  1  one-cycle pulse with done for an illegal command
out_en  input  1  read request
out_addr  input  AW  register to read
dataout  output  WIDTH  registered read data

Behaviour:
- Reset (rst low, async): FSM to IDLE; all registers, P, accumulators and outputs to 0. After reset, busy=0, done=0, err=0, dataout=0, cmd_ready=1.
- FSM states: IDLE, ADDSUB, MUL, WRITE.
  - cmd_ready = (state==IDLE); busy = !cmd_ready.
  - A command is accepted on the edge where cmd_valid & cmd_ready. On that edge A=reg[src_a], B=reg[src_b], P, op and dst are latched. Later loads do not affect a running command.
- IDLE -> ADDSUB (op 00/01), MUL (op 10), WRITE with error (op 11, or any address >= NREG).
- ADDSUB, 1 cycle:
  - madd: s=A+B in WIDTH+1 bits; r = (s>=P) ? s-P : s.
  - msub: d=A-B; r = borrow ? d+P : d, truncated to WIDTH.
- MUL, exactly WIDTH cycles: interleaved MSB-first.
  - Per cycle: acc=2*acc mod P; if the current bit of B is 1, acc=acc+A mod P.
  - Internal width is WIDTH+2. Each reduction is a single conditional subtract.
- Operands are required to be < P, with P odd and > 1. Otherwise the formulas above still apply bit-exactly, but the result is not a field element.
- WRITE, 1 cycle: reg[dst]=r (skipped on error); done=1; err=1 on error. Then -> IDLE.
- Latency from the accept edge to the edge setting done:
  - madd/msub: 2 cycles
  - mmul: WIDTH+1 cycles
  - error: 1 cycle
- Back-to-back: the next command can be accepted in the cycle after done.
- Load to the same register on the result-write edge: result wins, load dropped.
- load_en with load_addr >= NREG: ignored.
- load_mod while busy: ignored; P is only changed in IDLE.
- Read port: on an out_en edge, dataout = reg[out_addr], or P when out_addr == NREG if NREG < 2**AW, otherwise 0. dataout holds when out_en=0.
- Mid-operation reset: aborts immediately, destination not written, no done.

Optional Feature:
PFCOP_RDFWD_EN:
- Defined: a read of a register being written on the same edge, by result or load, returns the new value in dataout.
- Undefined: the read returns the pre-write value.

Test Plan:
- Reset: rst low -> busy=0, done=0, err=0, cmd_ready=1, dataout=0. Read of every register returns 0.
- P=0xFFF1, r0=0xFFF0, r1=0x0005, madd dst=r2 -> done 2 cycles after accept; reading r2 gives 0x0004.
- P=0xFFF1, r0=0x0003, r1=0x0005, msub dst=r3 -> r3=0xFFEF.
- P=0xFFF1, mmul 0xFFF0*0xFFF0 -> 0x0001, done at accept+17. mmul 0x1234*0x0002 -> 0x2468. cmd_ready=0 and cmd_valid ignored throughout.
- cmd_op=11 -> done and err pulse together 1 cycle after accept; no register changes.
- Collision cases:
  - load_en to dst on the WRITE edge -> result retained.
  - rst low mid-mmul -> no done, all state 0.
  - Same-edge read of dst -> new value with PFCOP_RDFWD_EN, old value without.

Source files
------------

// File: rtl/pfcop_seq.sv
// Command-driven prime-field coprocessor: register file + modulus P, modular add/sub/mul.
// Optional macro PFCOP_RDFWD_EN: read port returns the value being written on the same edge.
module pfcop_seq #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned NREG  = 8,
    parameter int unsigned AW    = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load_en,
    input  logic [AW-1:0]    load_addr,
    input  logic             load_mod,
    input  logic [WIDTH-1:0] datain,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [1:0]       cmd_op,
    input  logic [AW-1:0]    cmd_src_a,
    input  logic [AW-1:0]    cmd_src_b,
    input  logic [AW-1:0]    cmd_dst,
    output logic             busy,
    output logic             done,
    output logic             err,
    input  logic             out_en,
    input  logic [AW-1:0]    out_addr,
    output logic [WIDTH-1:0] dataout
);

    localparam int unsigned CW         = $clog2(WIDTH + 1);
    localparam bit          P_READABLE = (NREG < (32'd1 << AW));

    typedef enum logic [1:0] {IDLE, ADDSUB, MUL, WRITE} state_e;
    typedef enum logic [1:0] {
        OP_MADD = 2'b00,
        OP_MSUB = 2'b01,
        OP_MMUL = 2'b10,
        OP_RSVD = 2'b11
    } op_e;

    state_e           state;
    op_e              op_q;
    op_e              cmd_op_e;
    logic [WIDTH-1:0] regs [NREG];
    logic [WIDTH-1:0] p_reg;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [WIDTH-1:0] p_q;
    logic [WIDTH-1:0] r_q;
    logic [AW-1:0]    dst_q;
    logic             err_q;
    logic [CW-1:0]    cnt;
    logic [WIDTH+1:0] acc;

    logic [WIDTH-1:0] src_a_val;
    logic [WIDTH-1:0] src_b_val;
    logic             cmd_bad;
    logic             wr_res;
    logic             mod_ok;
    logic [WIDTH-1:0] addsub_r;
    logic [WIDTH:0]   sum;
    logic [WIDTH:0]   diff;
    logic [WIDTH-1:0] red;
    logic [WIDTH+1:0] p_ext;
    logic [WIDTH+1:0] acc_dbl;
    logic [WIDTH+1:0] acc_sum;
    logic [WIDTH+1:0] acc_nxt;
    logic [WIDTH-1:0] rd_val;

    assign cmd_ready = (state == IDLE);
    assign busy      = ~cmd_ready;
    assign cmd_op_e  = op_e'(cmd_op);
    assign wr_res    = (state == WRITE) && !err_q;
    assign mod_ok    = load_mod && (state == IDLE);

    always_comb begin
        src_a_val = '0;
        src_b_val = '0;
        for (int unsigned i = 0; i < NREG; i++) begin
            if (cmd_src_a == AW'(i)) src_a_val = regs[i];
            if (cmd_src_b == AW'(i)) src_b_val = regs[i];
        end
    end

    assign cmd_bad = (cmd_op_e == OP_RSVD)
                  || (32'(cmd_src_a) >= NREG)
                  || (32'(cmd_src_b) >= NREG)
                  || (32'(cmd_dst)   >= NREG);

    always_comb begin
        sum      = {1'b0, a_q} + {1'b0, b_q};
        diff     = {1'b0, a_q} - {1'b0, b_q};
        red      = sum[WIDTH-1:0] - p_q;
        addsub_r = '0;
        if (op_q == OP_MSUB) begin
            addsub_r = diff[WIDTH] ? (diff[WIDTH-1:0] + p_q) : diff[WIDTH-1:0];
        end else begin
            addsub_r = (sum >= {1'b0, p_q}) ? red : sum[WIDTH-1:0];
        end
    end

    // One MSB-first multiply step: double, reduce, conditionally add A, reduce.
    always_comb begin
        p_ext   = {2'b00, p_q};
        acc_dbl = acc << 1;
        if (acc_dbl >= p_ext) acc_dbl = acc_dbl - p_ext;
        acc_sum = acc_dbl + (b_q[WIDTH-1] ? {2'b00, a_q} : '0);
        acc_nxt = acc_sum;
        if (acc_sum >= p_ext) acc_nxt = acc_sum - p_ext;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
            op_q  <= OP_MADD;
            a_q   <= '0;
            b_q   <= '0;
            p_q   <= '0;
            r_q   <= '0;
            dst_q <= '0;
            err_q <= 1'b0;
            cnt   <= '0;
            acc   <= '0;
            done  <= 1'b0;
            err   <= 1'b0;
        end else begin
            done <= 1'b0;
            err  <= 1'b0;
            case (state)
                IDLE: begin
                    if (cmd_valid) begin
                        a_q   <= src_a_val;
                        b_q   <= src_b_val;
                        p_q   <= p_reg;
                        op_q  <= cmd_op_e;
                        dst_q <= cmd_dst;
                        acc   <= '0;
                        cnt   <= '0;
                        err_q <= cmd_bad;
                        if (cmd_bad)                    state <= WRITE;
                        else if (cmd_op_e == OP_MMUL)   state <= MUL;
                        else                            state <= ADDSUB;
                    end
                end
                ADDSUB: begin
                    r_q   <= addsub_r;
                    state <= WRITE;
                end
                MUL: begin
                    acc <= acc_nxt;
                    b_q <= b_q << 1;
                    cnt <= cnt + CW'(1);
                    if (cnt == CW'(WIDTH - 1)) begin
                        r_q   <= acc_nxt[WIDTH-1:0];
                        state <= WRITE;
                    end
                end
                WRITE: begin
                    done  <= 1'b1;
                    err   <= err_q;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Result write is given priority over a load to the same register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int unsigned i = 0; i < NREG; i++) regs[i] <= '0;
            p_reg <= '0;
        end else begin
            for (int unsigned i = 0; i < NREG; i++) begin
                if (wr_res && dst_q == AW'(i))            regs[i] <= r_q;
                else if (load_en && load_addr == AW'(i))  regs[i] <= datain;
            end
            if (mod_ok) p_reg <= datain;
        end
    end

    always_comb begin
        rd_val = '0;
        for (int unsigned i = 0; i < NREG; i++) begin
            if (out_addr == AW'(i)) begin
`ifdef PFCOP_RDFWD_EN
                if (wr_res && dst_q == out_addr)            rd_val = r_q;
                else if (load_en && load_addr == out_addr)  rd_val = datain;
                else                                        rd_val = regs[i];
`else
                rd_val = regs[i];
`endif
            end
        end
        if (P_READABLE && 32'(out_addr) == NREG) begin
`ifdef PFCOP_RDFWD_EN
            rd_val = mod_ok ? datain : p_reg;
`else
            rd_val = p_reg;
`endif
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)        dataout <= '0;
        else if (out_en) dataout <= rd_val;
    end

endmodule

// File: tb/tb_pfcop_seq.sv
// Randomised self-checking bench for pfcop_seq against a modular-arithmetic reference model.
module tb_pfcop_seq;

    localparam int unsigned WIDTH = 16;
    localparam int unsigned NREG  = 6;
    localparam int unsigned AW    = 3;

    logic             clk = 1'b0;
    logic             rst;
    logic             load_en;
    logic [AW-1:0]    load_addr;
    logic             load_mod;
    logic [WIDTH-1:0] datain;
    logic             cmd_valid;
    logic             cmd_ready;
    logic [1:0]       cmd_op;
    logic [AW-1:0]    cmd_src_a;
    logic [AW-1:0]    cmd_src_b;
    logic [AW-1:0]    cmd_dst;
    logic             busy;
    logic             done;
    logic             err;
    logic             out_en;
    logic [AW-1:0]    out_addr;
    logic [WIDTH-1:0] dataout;

    pfcop_seq #(.WIDTH(WIDTH), .NREG(NREG), .AW(AW)) dut (
        .clk(clk), .rst(rst),
        .load_en(load_en), .load_addr(load_addr), .load_mod(load_mod), .datain(datain),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
        .cmd_src_a(cmd_src_a), .cmd_src_b(cmd_src_b), .cmd_dst(cmd_dst),
        .busy(busy), .done(done), .err(err),
        .out_en(out_en), .out_addr(out_addr), .dataout(dataout)
    );

    always #5 clk = ~clk;

    int unsigned      n_checks = 0;
    int unsigned      n_errors = 0;
    logic [WIDTH-1:0] mdl [NREG];
    logic [WIDTH-1:0] mdl_p;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [WIDTH-1:0] model_op(input int unsigned op, input logic [WIDTH-1:0] a,
                                                  input logic [WIDTH-1:0] b, input logic [WIDTH-1:0] p);
        longint unsigned la = a, lb = b, lp = p;
        case (op)
            0:       return WIDTH'((la + lb) % lp);
            1:       return WIDTH'((la + lp - lb) % lp);
            2:       return WIDTH'((la * lb) % lp);
            default: return '0;
        endcase
    endfunction

    task automatic do_load(input int unsigned addr, input logic [WIDTH-1:0] v);
        load_en = 1'b1; load_addr = AW'(addr); datain = v;
        tick();
        load_en = 1'b0;
        if (addr < NREG) mdl[addr] = v;
    endtask

    task automatic do_loadp(input logic [WIDTH-1:0] v);
        load_mod = 1'b1; datain = v;
        tick();
        load_mod = 1'b0;
        mdl_p = v;
    endtask

    task automatic rd(input int unsigned addr, output logic [WIDTH-1:0] v);
        out_en = 1'b1; out_addr = AW'(addr);
        tick();
        out_en = 1'b0;
        v = dataout;
    endtask

    task automatic chk_reg(input string tag, input int unsigned addr);
        logic [WIDTH-1:0] v, e;
        rd(addr, v);
        if (addr < NREG)       e = mdl[addr];
        else if (addr == NREG) e = mdl_p;
        else                   e = '0;
        chk(tag, 32'(v), 32'(e));
    endtask

    task automatic chk_all(input string tag);
        for (int unsigned a = 0; a < (1 << AW); a++) chk_reg($sformatf("%s.r%0d", tag, a), a);
    endtask

    task automatic run_cmd(input string tag, input int unsigned op, input int unsigned sa,
                           input int unsigned sb, input int unsigned d, input bit hold);
        bit               bad, busy_bad;
        int unsigned      lat, n;
        logic [WIDTH-1:0] exp_r;
        bad   = (op == 3) || (sa >= NREG) || (sb >= NREG) || (d >= NREG);
        lat   = bad ? 1 : ((op == 2) ? WIDTH + 1 : 2);
        exp_r = '0;
        if (!bad) exp_r = model_op(op, mdl[sa], mdl[sb], mdl_p);
        chk({tag, ".ready"}, 32'(cmd_ready), 32'd1);
        cmd_valid = 1'b1; cmd_op = 2'(op);
        cmd_src_a = AW'(sa); cmd_src_b = AW'(sb); cmd_dst = AW'(d);
        tick();
        if (!hold) cmd_valid = 1'b0;
        n = 0; busy_bad = 1'b0;
        while (!done && n < 200) begin
            if (cmd_ready !== 1'b0 || busy !== 1'b1) busy_bad = 1'b1;
            tick();
            n++;
        end
        cmd_valid = 1'b0;
        chk({tag, ".lat"}, n, lat);
        chk({tag, ".err"}, 32'(err), 32'(bad));
        chk({tag, ".busy"}, 32'(busy_bad), 32'd0);
        if (!bad) mdl[d] = exp_r;
        tick();
        chk({tag, ".pulse"}, 32'(done), 32'd0);
        if (!bad) chk_reg({tag, ".res"}, d);
    endtask

    initial begin : main
        logic [WIDTH-1:0] v, old_v, exp_r;
        int unsigned      pv, op, sa, sb, d;
        bit               saw_done;

        rst = 1'b0; load_en = 1'b0; load_addr = '0; load_mod = 1'b0; datain = '0;
        cmd_valid = 1'b0; cmd_op = '0; cmd_src_a = '0; cmd_src_b = '0; cmd_dst = '0;
        out_en = 1'b0; out_addr = '0;
        for (int unsigned i = 0; i < NREG; i++) mdl[i] = '0;
        mdl_p = '0;
        tick(); tick();
        chk("rst.busy", 32'(busy), 32'd0);
        chk("rst.done", 32'(done), 32'd0);
        chk("rst.err", 32'(err), 32'd0);
        chk("rst.ready", 32'(cmd_ready), 32'd1);
        chk("rst.dataout", 32'(dataout), 32'd0);
        rst = 1'b1;
        tick();
        chk_all("rst");

        do_loadp(16'hFFF1);
        do_load(0, 16'hFFF0);
        do_load(1, 16'h0005);
        run_cmd("madd", 0, 0, 1, 2, 1'b0);
        rd(2, v); chk("madd.const", 32'(v), 32'h0004);

        do_load(0, 16'h0003);
        run_cmd("msub", 1, 0, 1, 3, 1'b0);
        rd(3, v); chk("msub.const", 32'(v), 32'hFFEF);

        do_load(0, 16'hFFF0);
        run_cmd("mmul_sq", 2, 0, 0, 4, 1'b1);
        rd(4, v); chk("mmul_sq.const", 32'(v), 32'h0001);
        do_load(0, 16'h1234);
        do_load(1, 16'h0002);
        run_cmd("mmul_x2", 2, 0, 1, 5, 1'b1);
        rd(5, v); chk("mmul_x2.const", 32'(v), 32'h2468);

        run_cmd("rsvd", 3, 0, 1, 0, 1'b0);
        run_cmd("bad_src", 0, 7, 1, 2, 1'b0);
        run_cmd("bad_dst", 1, 0, 1, 6, 1'b0);
        chk_all("post_err");

        do_load(6, 16'hBEEF);
        do_load(7, 16'hCAFE);
        chk_reg("ld_oob.p", NREG);
        chk_reg("ld_oob.r7", 7);

        // Load to destination on the write edge, and load_mod while busy.
        exp_r = model_op(0, mdl[0], mdl[1], mdl_p);
        cmd_valid = 1'b1; cmd_op = 2'd0; cmd_src_a = 3'd0; cmd_src_b = 3'd1; cmd_dst = 3'd2;
        tick();
        cmd_valid = 1'b0;
        load_mod = 1'b1; datain = 16'h0101;
        tick();
        load_mod = 1'b0;
        load_en = 1'b1; load_addr = 3'd2; datain = 16'hAAAA;
        tick();
        load_en = 1'b0;
        chk("colA.done", 32'(done), 32'd1);
        mdl[2] = exp_r;
        chk_reg("colA.dst", 2);
        chk_reg("colA.p", NREG);

        // Same-edge read of the destination.
        old_v = mdl[3];
        exp_r = model_op(1, mdl[0], mdl[1], mdl_p);
        cmd_valid = 1'b1; cmd_op = 2'd1; cmd_src_a = 3'd0; cmd_src_b = 3'd1; cmd_dst = 3'd3;
        tick();
        cmd_valid = 1'b0;
        tick();
        out_en = 1'b1; out_addr = 3'd3;
        tick();
        out_en = 1'b0;
        chk("colB.done", 32'(done), 32'd1);
`ifdef PFCOP_RDFWD_EN
        chk("colB.read", 32'(dataout), 32'(exp_r));
`else
        chk("colB.read", 32'(dataout), 32'(old_v));
`endif
        mdl[3] = exp_r;
        tick();

        // Same-edge read of a register being loaded.
        old_v = mdl[4];
        out_en = 1'b1; out_addr = 3'd4; load_en = 1'b1; load_addr = 3'd4; datain = 16'h5A5A;
        tick();
        out_en = 1'b0; load_en = 1'b0;
`ifdef PFCOP_RDFWD_EN
        chk("colC.read", 32'(dataout), 32'h5A5A);
`else
        chk("colC.read", 32'(dataout), 32'(old_v));
`endif
        mdl[4] = 16'h5A5A;
        chk_reg("colC.reg", 4);

        for (int it = 0; it < 8; it++) begin
            pv = ($urandom_range(32767, 1) * 2) + 1;
            do_loadp(WIDTH'(pv));
            for (int unsigned i = 0; i < NREG; i++) do_load(i, WIDTH'($urandom % pv));
            for (int k = 0; k < 6; k++) begin
                op = $urandom % 4;
                sa = ($urandom % 10 == 0) ? 6 + ($urandom % 2) : $urandom % NREG;
                sb = ($urandom % 10 == 0) ? 6 + ($urandom % 2) : $urandom % NREG;
                d  = ($urandom % 10 == 0) ? 6 + ($urandom % 2) : $urandom % NREG;
                run_cmd($sformatf("rnd%0d_%0d", it, k), op, sa, sb, d, ($urandom % 2) == 1);
            end
            chk_all($sformatf("rnd%0d", it));
        end

        // Reset in the middle of a multiply.
        do_loadp(16'hFFF1);
        do_load(0, 16'h0007);
        do_load(1, 16'h0009);
        cmd_valid = 1'b1; cmd_op = 2'd2; cmd_src_a = 3'd0; cmd_src_b = 3'd1; cmd_dst = 3'd2;
        tick();
        cmd_valid = 1'b0;
        rd(0, v);
        chk("mrst.pre_read", 32'(v), 32'h0007);
        tick(); tick();
        rst = 1'b0;
        #1;
        chk("mrst.busy", 32'(busy), 32'd0);
        chk("mrst.done", 32'(done), 32'd0);
        chk("mrst.err", 32'(err), 32'd0);
        chk("mrst.ready", 32'(cmd_ready), 32'd1);
        chk("mrst.dataout", 32'(dataout), 32'd0);
        tick();
        rst = 1'b1;
        for (int unsigned i = 0; i < NREG; i++) mdl[i] = '0;
        mdl_p = '0;
        saw_done = 1'b0;
        for (int unsigned c = 0; c < WIDTH + 5; c++) begin
            tick();
            if (done) saw_done = 1'b1;
        end
        chk("mrst.no_done", 32'(saw_done), 32'd0);
        chk_all("mrst");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
